// File: rtl/pwm_pkg.sv
// ============================================================================
// Module      : pwm_pkg
// Description : Shared PWM width, duty limit and ramp state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

    localparam int PWM_W             = 11;
    localparam int PWM_MAX_DUTY      = (1 << PWM_W) - 1;
    localparam int PWM_PERIOD_CYCLES = 1 << PWM_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        DECEL = 2'd2,
        DEAD  = 2'd3
    } ramp_state_t;

endpackage

`default_nettype wire

// File: rtl/pwm_period_tick.sv
// ============================================================================
// Module      : pwm_period_tick
// Description : Free-running period counter; tick marks the last clk of each period.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_period_tick
    import pwm_pkg::*;
#(
    parameter int PERIOD_CYCLES = PWM_PERIOD_CYCLES
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    assign tick = (r_count == LAST);

endmodule

`default_nettype wire

// File: rtl/pwm_duty_ramp.sv
// ============================================================================
// Module      : pwm_duty_ramp
// Description : Slew-limited duty/direction command stage with dead-time reversal.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int W                = PWM_W,
    parameter int PERIOD_CYCLES    = PWM_PERIOD_CYCLES,
    parameter int STEP             = 16,
    parameter int MAX_DUTY         = PWM_MAX_DUTY,
    parameter int DEADTIME_PERIODS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W-1:0] cmd_duty,
    input  logic         cmd_dir,
    input  logic         estop,
    output logic [W-1:0] pwm_count,
    output logic         dir,
    output logic         at_target,
    output logic         tick
);

    localparam int            DW        = $clog2(DEADTIME_PERIODS + 1);
    localparam logic [W:0]    STEP_W    = (W+1)'(STEP);
    localparam logic [W:0]    MAX_W     = (W+1)'(MAX_DUTY);
    localparam logic [W-1:0]  MAX_D     = W'(MAX_DUTY);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEADTIME_PERIODS);

    ramp_state_t   r_state, w_state_nxt;
    logic [W-1:0]  r_cur, w_cur_nxt;
    logic [W-1:0]  r_target, w_target_nxt;
    logic          r_dir, w_dir_nxt;
    logic          r_target_dir, w_target_dir_nxt;
    logic [DW-1:0] r_dead_cnt, w_dead_nxt;

    logic          w_tick;
    logic          w_accept;
    logic [W-1:0]  w_cmd_sat;
    logic [W:0]    w_cur_ext, w_tgt_ext, w_gap, w_ramp_ext, w_decel_ext;
    logic [W-1:0]  w_ramp_val, w_decel_val;
    logic [DW-1:0] w_dead_inc;

    pwm_period_tick #(
        .PERIOD_CYCLES (PERIOD_CYCLES)
    ) u_period_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    assign cmd_ready = (r_state != DEAD) && !estop;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_cmd_sat = ({1'b0, cmd_duty} > MAX_W) ? MAX_D : cmd_duty;
    assign w_dead_inc = r_dead_cnt + DW'(1);

    // Step arithmetic is one bit wider so neither direction can wrap.
    always_comb begin
        w_cur_ext = {1'b0, r_cur};
        w_tgt_ext = {1'b0, r_target};
        if (w_tgt_ext >= w_cur_ext) begin
            w_gap      = w_tgt_ext - w_cur_ext;
            w_ramp_ext = (w_gap <= STEP_W) ? w_tgt_ext : (w_cur_ext + STEP_W);
        end else begin
            w_gap      = w_cur_ext - w_tgt_ext;
            w_ramp_ext = (w_gap <= STEP_W) ? w_tgt_ext : (w_cur_ext - STEP_W);
        end
        w_ramp_val  = (w_ramp_ext > MAX_W) ? MAX_D : w_ramp_ext[W-1:0];
        w_decel_ext = w_cur_ext - STEP_W;
        w_decel_val = w_decel_ext[W] ? '0 : w_decel_ext[W-1:0];
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cur_nxt        = r_cur;
        w_target_nxt     = r_target;
        w_dir_nxt        = r_dir;
        w_target_dir_nxt = r_target_dir;
        w_dead_nxt       = r_dead_cnt;

        if (w_tick) begin
            case (r_state)
                RAMP: begin
                    w_cur_nxt = w_ramp_val;
                    if (w_ramp_val == r_target) begin
                        w_state_nxt = IDLE;
                    end
                end
                DECEL: begin
                    w_cur_nxt = w_decel_val;
                    if (w_decel_val == '0) begin
                        w_state_nxt = DEAD;
                        w_dead_nxt  = '0;
                    end
                end
                DEAD: begin
                    w_cur_nxt = '0;
                    if (w_dead_inc == DEAD_LAST) begin
                        w_dir_nxt   = r_target_dir;
                        w_dead_nxt  = '0;
                        w_state_nxt = (r_target != '0) ? RAMP : IDLE;
                    end else begin
                        w_dead_nxt  = w_dead_inc;
                    end
                end
                default: begin
                end
            endcase
        end

        // The tick above already used the old target; the new one takes effect next tick.
        if (w_accept) begin
            w_target_nxt     = w_cmd_sat;
            w_target_dir_nxt = cmd_dir;
            if (cmd_dir == r_dir) begin
                w_state_nxt = RAMP;
            end else if (w_state_nxt != DEAD) begin
                w_state_nxt = DECEL;
            end
        end

        if (estop) begin
            w_state_nxt      = IDLE;
            w_cur_nxt        = '0;
            w_target_nxt     = '0;
            w_target_dir_nxt = r_dir;
            w_dead_nxt       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cur        <= '0;
            r_target     <= '0;
            r_dir        <= 1'b0;
            r_target_dir <= 1'b0;
            r_dead_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cur        <= w_cur_nxt;
            r_target     <= w_target_nxt;
            r_dir        <= w_dir_nxt;
            r_target_dir <= w_target_dir_nxt;
            r_dead_cnt   <= w_dead_nxt;
        end
    end

    assign pwm_count = r_cur;
    assign dir       = r_dir;
    assign tick      = w_tick;
    assign at_target = (r_state == IDLE) && (r_cur == r_target) && (r_dir == r_target_dir);

endmodule

`default_nettype wire

// File: tb/tb_pwm_duty_ramp.sv
// ============================================================================
// Module      : tb_pwm_duty_ramp
// Description : Self-checking bench for pwm_duty_ramp against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_duty_ramp;

    localparam int W    = 11;
    localparam int PER  = 16;
    localparam int STEP = 100;
    localparam int MAXD = 2047;
    localparam int DT   = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_dir = 1'b0;
    logic         estop = 1'b0;
    logic [W-1:0] cmd_duty = '0;
    logic         cmd_ready, dir, at_target, tick;
    logic [W-1:0] pwm_count;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model: duty magnitude, direction, latest target, remaining dead periods (-1 = none),
    // and whether the output is still travelling toward an accepted command.
    int m_pc = 0, m_cur = 0, m_tgt = 0, m_dead = -1;
    bit m_dir = 1'b0, m_tdir = 1'b0, m_fresh = 1'b0, m_tk, m_acc;

    always #5 clk = ~clk;

    pwm_duty_ramp #(
        .W                (W),
        .PERIOD_CYCLES    (PER),
        .STEP             (STEP),
        .MAX_DUTY         (MAXD),
        .DEADTIME_PERIODS (DT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_duty  (cmd_duty),
        .cmd_dir   (cmd_dir),
        .estop     (estop),
        .pwm_count (pwm_count),
        .dir       (dir),
        .at_target (at_target),
        .tick      (tick)
    );

    function automatic bit m_ready();
        return (m_dead < 0) && !estop;
    endfunction

    function automatic bit m_at();
        return !m_fresh && (m_cur == m_tgt) && (m_dir == m_tdir) && (m_dead < 0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_pc = 0; m_cur = 0; m_tgt = 0; m_dead = -1;
            m_dir = 1'b0; m_tdir = 1'b0; m_fresh = 1'b0;
        end else begin
            m_tk  = (m_pc == PER - 1);
            m_acc = cmd_valid && m_ready();
            m_pc  = (m_pc + 1) % PER;
            if (estop) begin
                m_cur = 0; m_tgt = 0; m_tdir = m_dir; m_dead = -1; m_fresh = 1'b0;
            end else begin
                if (m_tk) begin
                    if (m_dead >= 0) begin
                        m_dead--;
                        if (m_dead == 0) begin
                            m_dead  = -1;
                            m_dir   = m_tdir;
                            m_fresh = (m_tgt != 0);
                        end
                    end else if (m_dir != m_tdir) begin
                        m_cur = (m_cur > STEP) ? m_cur - STEP : 0;
                        if (m_cur == 0) m_dead = DT;
                    end else if (m_fresh) begin
                        if (m_tgt > m_cur) m_cur = (m_tgt - m_cur <= STEP) ? m_tgt : m_cur + STEP;
                        else               m_cur = (m_cur - m_tgt <= STEP) ? m_tgt : m_cur - STEP;
                        if (m_cur > MAXD) m_cur = MAXD;
                        if (m_cur == m_tgt) m_fresh = 1'b0;
                    end
                end
                if (m_acc) begin
                    m_tgt = (int'(cmd_duty) > MAXD) ? MAXD : int'(cmd_duty);
                    if (cmd_dir == m_dir) m_dead = -1;
                    m_tdir  = cmd_dir;
                    m_fresh = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pwm_count", 32'(pwm_count), 32'(m_cur));
            chk("dir",       32'(dir),       32'(m_dir));
            chk("cmd_ready", 32'(cmd_ready), 32'(m_ready()));
            chk("at_target", 32'(at_target), 32'(m_at()));
            chk("tick",      32'(tick),      32'(m_pc == PER - 1));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int duty, input bit d);
        step(1);
        cmd_valid = 1'b1;
        cmd_duty  = W'(duty);
        cmd_dir   = d;
        step(1);
        cmd_valid = 1'b0;
    endtask

    // Returns at the falling edge of the first cycle after the next tick.
    task automatic next_period();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2 * PER + 2 && !seen; i++) begin
            @(negedge clk);
            if (tick === 1'b1) seen = 1'b1;
        end
        if (!seen) chk("tick_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int ticks;
        step(1);
        chk_en = 1'b1;
        step(2);
        rst = 1'b0;

        // Reset values and tick cadence
        @(negedge clk);
        chk("rst_pwm", 32'(pwm_count), 32'd0);
        chk("rst_dir", 32'(dir), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_at", 32'(at_target), 32'd1);
        ticks = (tick === 1'b1) ? 1 : 0;
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            if (tick === 1'b1) ticks++;
        end
        chk("tick_count", 32'(ticks), 32'd2);

        // Forward ramp to 350
        send(350, 1'b0);
        next_period(); chk("up1", 32'(pwm_count), 32'd100);
        next_period(); chk("up2", 32'(pwm_count), 32'd200);
        next_period(); chk("up3", 32'(pwm_count), 32'd300);
        next_period(); chk("up4", 32'(pwm_count), 32'd350);
        chk("up_at", 32'(at_target), 32'd1);

        // Reversal to 150 rev through dead time
        send(150, 1'b1);
        next_period(); chk("rev1", 32'(pwm_count), 32'd250);
        next_period(); chk("rev2", 32'(pwm_count), 32'd150);
        next_period(); chk("rev3", 32'(pwm_count), 32'd50);
        next_period(); chk("rev4", 32'(pwm_count), 32'd0);
        chk("dead_ready", 32'(cmd_ready), 32'd0);
        next_period(); chk("dead_dir", 32'(dir), 32'd0);
        next_period(); chk("flip_dir", 32'(dir), 32'd1);
        chk("flip_pwm", 32'(pwm_count), 32'd0);
        next_period(); chk("rev_up1", 32'(pwm_count), 32'd100);
        next_period(); chk("rev_up2", 32'(pwm_count), 32'd150);
        chk("rev_at", 32'(at_target), 32'd1);

        // Same-direction command cancels a deceleration
        send(350, 1'b1);
        next_period(); next_period(); chk("pre_dec", 32'(pwm_count), 32'd350);
        send(0, 1'b0);
        next_period(); chk("dec1", 32'(pwm_count), 32'd250);
        send(400, 1'b1);
        next_period(); chk("cancel1", 32'(pwm_count), 32'd350);
        next_period(); chk("cancel2", 32'(pwm_count), 32'd400);
        chk("cancel_dir", 32'(dir), 32'd1);

        // Top-of-range ramp
        send(2000, 1'b1);
        for (int i = 0; i < 24 && (at_target !== 1'b1); i++) next_period();
        chk("hi_pre", 32'(pwm_count), 32'd2000);
        send(2047, 1'b1);
        next_period(); chk("hi_max", 32'(pwm_count), 32'd2047);

        // Emergency stop mid-period, command during estop is dropped
        step(4);
        estop = 1'b1; cmd_valid = 1'b1; cmd_duty = W'(500); cmd_dir = 1'b0;
        @(negedge clk); chk("es_ready", 32'(cmd_ready), 32'd0);
        step(1);
        @(negedge clk); chk("es_pwm", 32'(pwm_count), 32'd0);
        chk("es_dir", 32'(dir), 32'd1);
        step(2);
        estop = 1'b0; cmd_valid = 1'b0;
        @(negedge clk); chk("es_rel_at", 32'(at_target), 32'd1);
        send(300, 1'b1);
        next_period(); next_period(); next_period();
        chk("es2_pre", 32'(pwm_count), 32'd300);
        step(5);
        estop = 1'b1;
        step(1);
        @(negedge clk); chk("es2_pwm", 32'(pwm_count), 32'd0);
        step(2);
        estop = 1'b0;

        // Command accepted on the tick cycle uses the old target for that tick
        next_period();
        repeat (15) @(posedge clk);
        #1;
        cmd_valid = 1'b1; cmd_duty = W'(200); cmd_dir = 1'b1;
        step(1);
        cmd_valid = 1'b0;
        @(negedge clk); chk("tk_acc_old", 32'(pwm_count), 32'd0);
        next_period(); chk("tk_acc1", 32'(pwm_count), 32'd100);
        next_period(); chk("tk_acc2", 32'(pwm_count), 32'd200);

        // Zero-magnitude reversal still waits out the dead time
        send(0, 1'b1);
        next_period(); next_period(); chk("z_pre", 32'(pwm_count), 32'd0);
        send(0, 1'b0);
        next_period(); chk("z_dead", 32'(cmd_ready), 32'd0);
        next_period(); chk("z_dead_dir", 32'(dir), 32'd1);
        next_period(); chk("z_flip", 32'(dir), 32'd0);
        chk("z_at", 32'(at_target), 32'd1);

        // Reset in the middle of a ramp
        send(500, 1'b0);
        next_period(); next_period(); chk("r_pre", 32'(pwm_count), 32'd200);
        step(6);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        chk("r_pwm", 32'(pwm_count), 32'd0);
        chk("r_at", 32'(at_target), 32'd1);
        chk("r_tick", 32'(tick), 32'd0);
        step(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
